t06_apple_spawn_ctrl: RTL and testbench

- Sequencer that serves apple respawn requests from two apple slots: slot 0 is the normal apple, slot 1 is the two-apple-mode apple.
- Uses a single shared random-number generator and a single occupancy checker.
- For each request it draws candidate cells until one passes the checks, or until the retry budget runs out:
  - inside the play bounds;
  - not a wall;
  - not the snake head or any body segment;
  - not the other apple.
- Sits between the collision logic and the apple-location registers that feed the display.

---
 rtl/t06_apple_pkg.sv | 24 ++
 rtl/t06_occupancy_check.sv | 46 ++++
 rtl/t06_apple_spawn_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_t06_apple_spawn_ctrl.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/t06_apple_pkg.sv
// Shared types and constants for the apple respawn sequencer.
// ST_RASTER exists only when APPLE_FALLBACK_SCAN_EN is defined.
package t06_apple_pkg;

    localparam int COORD_W = 4;
    localparam int CELL_W  = 2 * COORD_W;

    localparam logic [CELL_W-1:0] LOC_RESET    = 8'h55;
    localparam logic [CELL_W-1:0] LOC_DISABLED = 8'h00;

    typedef logic slot_t;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_DRAW   = 3'd1;
    localparam state_t ST_CHECK  = 3'd2;
    localparam state_t ST_SCAN   = 3'd3;
    localparam state_t ST_COMMIT = 3'd4;
    localparam state_t ST_FAIL   = 3'd5;
`ifdef APPLE_FALLBACK_SCAN_EN
    localparam state_t ST_RASTER = 3'd6;
`endif

endpackage

// File: rtl/t06_occupancy_check.sv
// Combinational single-cell test: play bounds, wall bitmap, snake head and other apple.
// Body segments are checked separately, one per cycle, by the sequencer.
module t06_occupancy_check
    import t06_apple_pkg::*;
#(
    parameter int WALL_BITS = 200
) (
    input  logic [CELL_W-1:0]    cand,
    input  logic [COORD_W-1:0]   xmin,
    input  logic [COORD_W-1:0]   xmax,
    input  logic [COORD_W-1:0]   ymin,
    input  logic [COORD_W-1:0]   ymax,
    input  logic [WALL_BITS-1:0] wall_locations,
    input  logic [COORD_W-1:0]   head_x,
    input  logic [COORD_W-1:0]   head_y,
    input  logic [CELL_W-1:0]    other_loc,
    input  logic                 other_valid,
    output logic                 reject
);

    localparam int CELLS = 1 << CELL_W;
    localparam int USE_W = (WALL_BITS < CELLS) ? WALL_BITS : CELLS;

    logic [CELLS-1:0]   wall_pad;
    logic [COORD_W-1:0] cx;
    logic [COORD_W-1:0] cy;
    logic               out_of_bounds;
    logic               wall_hit;
    logic               head_hit;
    logic               other_hit;

    // Cells at or beyond WALL_BITS read as zero padding, i.e. never a wall.
    always_comb begin
        wall_pad              = '0;
        wall_pad[USE_W-1:0]   = wall_locations[USE_W-1:0];
    end

    assign cx            = cand[COORD_W-1:0];
    assign cy            = cand[CELL_W-1:COORD_W];
    assign out_of_bounds = (cx < xmin) || (cx > xmax) || (cy < ymin) || (cy > ymax);
    assign wall_hit      = wall_pad[cand];
    assign head_hit      = (cx == head_x) && (cy == head_y);
    assign other_hit     = other_valid && (cand == other_loc);
    assign reject        = out_of_bounds || wall_hit || head_hit || other_hit;

endmodule

// File: rtl/t06_apple_spawn_ctrl.sv
// Apple respawn sequencer: arbitrates two slots, draws candidates, checks and commits them.
// Define APPLE_FALLBACK_SCAN_EN to raster-scan from the last candidate instead of failing.
module t06_apple_spawn_ctrl
    import t06_apple_pkg::*;
#(
    parameter int MAX_LENGTH = 30,
    parameter int MAX_TRIES  = 8,
    parameter int WALL_BITS  = 200
) (
    input  logic                          system_clk,
    input  logic                          nreset,
    input  logic                          req0,
    input  logic                          req1,
    input  logic                          two_apple_en,
    input  logic [CELL_W-1:0]             rng_value,
    output logic                          rng_step,
    input  logic [COORD_W-1:0]            snake_head_x,
    input  logic [COORD_W-1:0]            snake_head_y,
    input  logic [4:0]                    snake_len,
    input  logic [MAX_LENGTH*COORD_W-1:0] snakeArrayX,
    input  logic [MAX_LENGTH*COORD_W-1:0] snakeArrayY,
    input  logic [COORD_W-1:0]            xmin,
    input  logic [COORD_W-1:0]            xmax,
    input  logic [COORD_W-1:0]            ymin,
    input  logic [COORD_W-1:0]            ymax,
    input  logic [WALL_BITS-1:0]          wall_locations,
    output logic [CELL_W-1:0]             apple_loc0,
    output logic [CELL_W-1:0]             apple_loc1,
    output logic                          busy,
    output logic                          done,
    output logic                          fail
);

    localparam int LEN_W  = 5;
    localparam int TRY_W  = $clog2(MAX_TRIES + 1);
    localparam int SEG_IW = $clog2(MAX_LENGTH * COORD_W);
    localparam logic [LEN_W-1:0] MAX_LEN_L   = LEN_W'(MAX_LENGTH);
    localparam logic [TRY_W-1:0] MAX_TRIES_L = TRY_W'(MAX_TRIES);

    state_t             state;
    state_t             retry_state;
    logic [1:0]         pending;
    logic [1:0]         pending_eff;
    logic [1:0]         pending_n;
    logic [1:0]         grant_mask;
    logic               grant_valid;
    slot_t              grant_slot;
    slot_t              rr_ptr;
    slot_t              slot;
    logic               abort;
    logic [TRY_W-1:0]   tries;
    logic [LEN_W-1:0]   idx;
    logic [LEN_W-1:0]   len_c;
    logic [CELL_W-1:0]  cand;
    logic [CELL_W-1:0]  other_loc;
    logic               other_valid;
    logic               occ_reject;
    logic [SEG_IW-1:0]  seg_base;
    logic [COORD_W-1:0] seg_x;
    logic [COORD_W-1:0] seg_y;
    logic               seg_hit;
`ifdef APPLE_FALLBACK_SCAN_EN
    logic               in_raster;
    logic [8:0]         raster_cnt;
`endif

    // Slot 1 is invisible to arbitration while two-apple mode is off.
    assign pending_eff = {pending[1] & two_apple_en, pending[0]};
    assign grant_valid = (state == ST_IDLE) && (pending_eff != 2'b00);
    assign grant_slot  = (pending_eff == 2'b11) ? ~rr_ptr : pending_eff[1];
    assign grant_mask  = grant_valid ? (grant_slot ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        pending_n = (pending | {req1 & two_apple_en, req0}) & ~grant_mask;
        if (!two_apple_en) begin
            pending_n[1] = 1'b0;
        end
    end

    assign abort = (state != ST_IDLE) && slot && !two_apple_en;

    assign other_loc   = slot ? apple_loc0 : apple_loc1;
    assign other_valid = slot ? 1'b1 : two_apple_en;

    t06_occupancy_check #(
        .WALL_BITS(WALL_BITS)
    ) u_occupancy (
        .cand          (cand),
        .xmin          (xmin),
        .xmax          (xmax),
        .ymin          (ymin),
        .ymax          (ymax),
        .wall_locations(wall_locations),
        .head_x        (snake_head_x),
        .head_y        (snake_head_y),
        .other_loc     (other_loc),
        .other_valid   (other_valid),
        .reject        (occ_reject)
    );

    assign len_c    = (snake_len > MAX_LEN_L) ? MAX_LEN_L : snake_len;
    assign seg_base = SEG_IW'(idx) * SEG_IW'(COORD_W);
    assign seg_x    = snakeArrayX[seg_base +: COORD_W];
    assign seg_y    = snakeArrayY[seg_base +: COORD_W];
    assign seg_hit  = (seg_x == cand[COORD_W-1:0]) && (seg_y == cand[CELL_W-1:COORD_W]);

`ifdef APPLE_FALLBACK_SCAN_EN
    assign retry_state = (in_raster || (tries >= MAX_TRIES_L)) ? ST_RASTER : ST_DRAW;
`else
    assign retry_state = (tries < MAX_TRIES_L) ? ST_DRAW : ST_FAIL;
`endif

    always_ff @(posedge system_clk or negedge nreset) begin
        if (!nreset) begin
            state      <= ST_IDLE;
            pending    <= 2'b00;
            rr_ptr     <= 1'b0;
            slot       <= 1'b0;
            tries      <= '0;
            idx        <= '0;
            apple_loc0 <= LOC_RESET;
            apple_loc1 <= LOC_RESET;
`ifdef APPLE_FALLBACK_SCAN_EN
            in_raster  <= 1'b0;
            raster_cnt <= '0;
`endif
        end else begin
            pending <= pending_n;
            if (abort) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (grant_valid) begin
                            slot   <= grant_slot;
                            rr_ptr <= grant_slot;
                            tries  <= '0;
                            state  <= ST_DRAW;
`ifdef APPLE_FALLBACK_SCAN_EN
                            in_raster  <= 1'b0;
                            raster_cnt <= '0;
`endif
                        end
                    end
                    ST_DRAW: begin
                        tries <= tries + 1'b1;
                        state <= ST_CHECK;
                    end
                    ST_CHECK: begin
                        if (occ_reject) begin
                            state <= retry_state;
                        end else if (len_c == '0) begin
                            state <= ST_COMMIT;
                        end else begin
                            idx   <= '0;
                            state <= ST_SCAN;
                        end
                    end
                    ST_SCAN: begin
                        if (seg_hit) begin
                            state <= retry_state;
                        end else if ((idx + 1'b1) >= len_c) begin
                            state <= ST_COMMIT;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    ST_COMMIT: begin
                        if (slot) begin
                            apple_loc1 <= cand;
                        end else begin
                            apple_loc0 <= cand;
                        end
                        state <= ST_IDLE;
                    end
`ifdef APPLE_FALLBACK_SCAN_EN
                    ST_RASTER: begin
                        in_raster <= 1'b1;
                        if (raster_cnt == 9'd256) begin
                            state <= ST_FAIL;
                        end else begin
                            raster_cnt <= raster_cnt + 1'b1;
                            state      <= ST_CHECK;
                        end
                    end
`endif
                    default: state <= ST_IDLE;
                endcase
            end
            if (!two_apple_en) begin
                apple_loc1 <= LOC_DISABLED;
            end
        end
    end

    // Candidate is pure data and needs no reset.
    always_ff @(posedge system_clk) begin
        if (state == ST_DRAW) begin
            cand <= rng_value;
`ifdef APPLE_FALLBACK_SCAN_EN
        end else if ((state == ST_RASTER) && (raster_cnt != 9'd256)) begin
            cand <= cand + 1'b1;
`endif
        end
    end

    assign busy     = (state != ST_IDLE);
    assign rng_step = (state == ST_DRAW) && !abort;
    assign done     = (state == ST_COMMIT) && !abort;
    assign fail     = (state == ST_FAIL) && !abort;

endmodule

// File: tb/tb_t06_apple_spawn_ctrl.sv
// Randomized bench for t06_apple_spawn_ctrl with a per-request outcome and latency model.
module tb_t06_apple_spawn_ctrl;

    localparam int MAX_LENGTH = 30;
    localparam int MAX_TRIES  = 8;
    localparam int WALL_BITS  = 200;

    typedef struct {
        logic       slot;
        logic       is_fail;
        logic [7:0] loc;
        int         steps;
        int         offset;
    } ev_t;

    logic                      system_clk = 1'b0;
    logic                      nreset = 1'b0;
    logic                      req0 = 1'b0;
    logic                      req1 = 1'b0;
    logic                      two_apple_en = 1'b0;
    logic [7:0]                rng_value = 8'h00;
    logic                      rng_step;
    logic [3:0]                snake_head_x, snake_head_y;
    logic [4:0]                snake_len;
    logic [MAX_LENGTH*4-1:0]   snakeArrayX, snakeArrayY;
    logic [3:0]                xmin, xmax, ymin, ymax;
    logic [WALL_BITS-1:0]      wall_locations;
    logic [7:0]                apple_loc0, apple_loc1;
    logic                      busy, done, fail;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] seq [0:63];
    int         d_ptr = 0;
    int         m_ptr = 0;
    logic [7:0] exp_loc [0:1];
    logic       m_rr = 1'b0;
    ev_t        exp_q [$];

    always #5 system_clk = ~system_clk;

    t06_apple_spawn_ctrl #(
        .MAX_LENGTH(MAX_LENGTH),
        .MAX_TRIES (MAX_TRIES),
        .WALL_BITS (WALL_BITS)
    ) dut (
        .system_clk    (system_clk),
        .nreset        (nreset),
        .req0          (req0),
        .req1          (req1),
        .two_apple_en  (two_apple_en),
        .rng_value     (rng_value),
        .rng_step      (rng_step),
        .snake_head_x  (snake_head_x),
        .snake_head_y  (snake_head_y),
        .snake_len     (snake_len),
        .snakeArrayX   (snakeArrayX),
        .snakeArrayY   (snakeArrayY),
        .xmin          (xmin),
        .xmax          (xmax),
        .ymin          (ymin),
        .ymax          (ymax),
        .wall_locations(wall_locations),
        .apple_loc0    (apple_loc0),
        .apple_loc1    (apple_loc1),
        .busy          (busy),
        .done          (done),
        .fail          (fail)
    );

    function automatic logic [3:0] seg_of(input logic [MAX_LENGTH*4-1:0] arr, input int j);
        logic [MAX_LENGTH*4-1:0] t;
        t = arr >> (4 * j);
        return t[3:0];
    endfunction

    function automatic int body_len();
        int n;
        n = int'(snake_len);
        if (n > MAX_LENGTH) n = MAX_LENGTH;
        return n;
    endfunction

    // Bounds, wall, head and other-apple rules for serving slot s.
    function automatic logic cell_blocked(input logic [7:0] c, input logic s);
        logic [3:0] x;
        logic [3:0] y;
        x = c[3:0];
        y = c[7:4];
        if (x < xmin || x > xmax || y < ymin || y > ymax) return 1'b1;
        if (int'(c) < WALL_BITS && wall_locations[c]) return 1'b1;
        if (x == snake_head_x && y == snake_head_y) return 1'b1;
        if (s) return (c == exp_loc[0]);
        return two_apple_en && (c == exp_loc[1]);
    endfunction

    function automatic int body_hit(input logic [7:0] c);
        for (int j = 0; j < body_len(); j++) begin
            if (seg_of(snakeArrayX, j) == c[3:0] && seg_of(snakeArrayY, j) == c[7:4]) return j;
        end
        return -1;
    endfunction

    // Outcome of one request: draw cost 2 cycles when rejected in check, 3+j when
    // segment j matches, 2+len to reach commit; offsets count from the first draw.
    task automatic model_job(input logic s);
        ev_t        e;
        int         acc;
        int         hit;
        logic [7:0] c;
        acc       = 0;
        e.slot    = s;
        e.is_fail = 1'b1;
        e.loc     = exp_loc[s];
        e.steps   = MAX_TRIES;
        for (int k = 0; k < MAX_TRIES; k++) begin
            c = seq[m_ptr];
            m_ptr++;
            if (cell_blocked(c, s)) begin
                acc += 2;
            end else begin
                hit = body_hit(c);
                if (hit >= 0) begin
                    acc += 3 + hit;
                end else begin
                    e.is_fail = 1'b0;
                    e.loc     = c;
                    e.steps   = k + 1;
                    acc += 2 + body_len();
                    break;
                end
            end
        end
        e.offset   = acc;
        exp_loc[s] = e.loc;
        m_rr       = s;
        exp_q.push_back(e);
    endtask

    task automatic set_seg(input int j, input logic [7:0] c);
        snakeArrayX[4*j +: 4] = c[3:0];
        snakeArrayY[4*j +: 4] = c[7:4];
    endtask

    task automatic env_default();
        xmin = 4'd0; xmax = 4'd15; ymin = 4'd0; ymax = 4'd15;
        wall_locations = '0;
        snake_head_x = 4'd0; snake_head_y = 4'd0;
        snake_len = 5'd3;
        snakeArrayX = '0; snakeArrayY = '0;
        set_seg(0, 8'h01); set_seg(1, 8'h02); set_seg(2, 8'h03);
        two_apple_en = 1'b1;
        for (int i = 0; i < 64; i++) seq[i] = 8'h00;
    endtask

    task automatic run_jobs(input logic r0, input logic r1, input string name);
        logic       first_slot;
        int         cyc, first, steps, got, pend_idx, offs;
        logic       stepped, pend_loc;
        logic [7:0] obs;
        exp_q.delete();
        m_ptr = 0; d_ptr = 0; rng_value = seq[0];
        if (r0 && r1 && two_apple_en) begin
            first_slot = ~m_rr;
            model_job(first_slot);
            model_job(~first_slot);
        end else if (r0) begin
            model_job(1'b0);
        end else if (r1 && two_apple_en) begin
            model_job(1'b1);
        end
        @(posedge system_clk); #1; req0 = r0; req1 = r1;
        @(posedge system_clk); #1; req0 = 1'b0; req1 = 1'b0;
        cyc = 0; first = -1; steps = 0; got = 0; stepped = 1'b0; pend_loc = 1'b0; pend_idx = 0;
        while ((got < exp_q.size() || pend_loc) && cyc < 1500) begin
            @(negedge system_clk);
            cyc++;
            if (pend_loc) begin
                obs = exp_q[pend_idx].slot ? apple_loc1 : apple_loc0;
                checks++;
                if (obs !== exp_q[pend_idx].loc) begin
                    errors++;
                    $display("FAIL %s loc job%0d: got %h expected %h", name, pend_idx, obs, exp_q[pend_idx].loc);
                end
                pend_loc = 1'b0;
            end
            if (rng_step) begin
                if (first < 0) first = cyc;
                steps++;
                stepped = 1'b1;
            end
            if (done || fail) begin
                if (got < exp_q.size()) begin
                    offs = (first < 0) ? -1 : cyc - first;
                    checks++;
                    if (fail !== exp_q[got].is_fail) begin
                        errors++;
                        $display("FAIL %s kind job%0d: got fail=%0b expected fail=%0b", name, got, fail, exp_q[got].is_fail);
                    end
                    checks++;
                    if (steps !== exp_q[got].steps) begin
                        errors++;
                        $display("FAIL %s rng_step count job%0d: got %0d expected %0d", name, got, steps, exp_q[got].steps);
                    end
                    checks++;
                    if (offs !== exp_q[got].offset) begin
                        errors++;
                        $display("FAIL %s latency job%0d: got %0d expected %0d", name, got, offs, exp_q[got].offset);
                    end
                    pend_loc = 1'b1; pend_idx = got; got++;
                    first = -1; steps = 0;
                end else begin
                    checks++; errors++;
                    $display("FAIL %s extra done/fail: got done=%0b fail=%0b expected none", name, done, fail);
                end
            end
            @(posedge system_clk); #1;
            if (stepped) begin
                d_ptr++;
                rng_value = seq[d_ptr];
                stepped = 1'b0;
            end
        end
        checks++;
        if (got < exp_q.size()) begin
            errors++;
            $display("FAIL %s timeout: got %0d events expected %0d", name, got, exp_q.size());
        end
        @(negedge system_clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle after jobs: got busy=%0b expected 0", name, busy);
        end
    endtask

    task automatic test_reset();
        env_default();
        nreset = 1'b0;
        #12;
        checks += 6;
        if (apple_loc0 !== 8'h55) begin errors++; $display("FAIL reset apple_loc0: got %h expected 55", apple_loc0); end
        if (apple_loc1 !== 8'h55) begin errors++; $display("FAIL reset apple_loc1: got %h expected 55", apple_loc1); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b expected 0", done); end
        if (fail !== 1'b0) begin errors++; $display("FAIL reset fail: got %b expected 0", fail); end
        if (rng_step !== 1'b0) begin errors++; $display("FAIL reset rng_step: got %b expected 0", rng_step); end
        @(posedge system_clk); #1;
        nreset = 1'b1;
        exp_loc[0] = 8'h55; exp_loc[1] = 8'h55; m_rr = 1'b0;
    endtask

    task automatic test_basic();
        env_default();
        seq[0] = 8'h37;
        run_jobs(1'b1, 1'b0, "basic");
    endtask

    task automatic test_rejects();
        env_default();
        wall_locations[18] = 1'b1;
        set_seg(1, 8'h34);
        seq[0] = 8'h12; seq[1] = 8'h34; seq[2] = 8'h56;
        run_jobs(1'b1, 1'b0, "rejects");
    endtask

    task automatic test_fail();
        env_default();
        xmax = 4'd0;
        for (int i = 0; i < 64; i++) seq[i] = 8'hFF;
        run_jobs(1'b1, 1'b0, "fail_budget");
    endtask

    task automatic test_two_apple();
        env_default();
        seq[0] = 8'hA9; seq[1] = 8'hA9; seq[2] = 8'hB3;
        run_jobs(1'b1, 1'b1, "two_apple");
        checks++;
        if (apple_loc0 === apple_loc1) begin
            errors++;
            $display("FAIL two_apple distinct: got loc0=%h loc1=%h expected different", apple_loc0, apple_loc1);
        end
    endtask

    task automatic test_random();
        int mode;
        for (int it = 0; it < 10; it++) begin
            env_default();
            xmin = 4'($urandom_range(0, 4));
            xmax = 4'($urandom_range(15, int'(xmin) + 6));
            ymin = 4'($urandom_range(0, 4));
            ymax = 4'($urandom_range(15, int'(ymin) + 6));
            for (int b = 0; b < WALL_BITS; b++)
                wall_locations = {wall_locations[WALL_BITS-2:0], ($urandom_range(0, 7) == 0)};
            snake_head_x = 4'($urandom);
            snake_head_y = 4'($urandom);
            snake_len = (it == 3) ? 5'd31 : 5'($urandom_range(0, 8));
            for (int j = 0; j < MAX_LENGTH; j++) set_seg(j, 8'($urandom));
            for (int i = 0; i < 64; i++) begin
                if ($urandom_range(0, 3) != 0)
                    seq[i] = {4'($urandom_range(int'(ymax), int'(ymin))), 4'($urandom_range(int'(xmax), int'(xmin)))};
                else
                    seq[i] = 8'($urandom);
            end
            mode = int'($urandom_range(0, 2));
            run_jobs(mode != 1, mode != 0, $sformatf("random%0d", it));
        end
    endtask

    task automatic test_abort();
        int dones;
        env_default();
        snake_len = 5'd20;
        for (int j = 0; j < 20; j++) set_seg(j, 8'hFF);
        seq[0] = 8'h37; rng_value = 8'h37;
        @(posedge system_clk); #1; req1 = 1'b1;
        @(posedge system_clk); #1; req1 = 1'b0;
        repeat (3) begin @(posedge system_clk); #1; end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL abort busy before: got %b expected 1", busy); end
        two_apple_en = 1'b0;
        @(posedge system_clk); #1;
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort busy after: got %b expected 0", busy); end
        if (apple_loc1 !== 8'h00) begin errors++; $display("FAIL abort apple_loc1: got %h expected 00", apple_loc1); end
        dones = 0;
        repeat (30) begin @(negedge system_clk); if (done) dones++; end
        checks++;
        if (dones !== 0) begin errors++; $display("FAIL abort done pulses: got %0d expected 0", dones); end
        exp_loc[1] = 8'h00; m_rr = 1'b1;
        two_apple_en = 1'b1;
    endtask

    task automatic test_disable();
        int busy_cnt;
        env_default();
        two_apple_en = 1'b0;
        @(posedge system_clk); #1; req1 = 1'b1;
        @(posedge system_clk); #1; req1 = 1'b0;
        busy_cnt = 0;
        repeat (8) begin @(negedge system_clk); if (busy) busy_cnt++; end
        checks += 2;
        if (busy_cnt !== 0) begin errors++; $display("FAIL disable busy cycles: got %0d expected 0", busy_cnt); end
        if (apple_loc1 !== 8'h00) begin errors++; $display("FAIL disable apple_loc1: got %h expected 00", apple_loc1); end
        two_apple_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        int busy_cnt;
        env_default();
        snake_len = 5'd10;
        for (int j = 0; j < 10; j++) set_seg(j, 8'hFF);
        seq[0] = 8'h37; rng_value = 8'h37;
        @(posedge system_clk); #1; req0 = 1'b1;
        @(posedge system_clk); #1; req0 = 1'b0;
        @(posedge system_clk); #1; req1 = 1'b1;
        @(posedge system_clk); #1; req1 = 1'b0;
        @(posedge system_clk); #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL reset_mid busy before: got %b expected 1", busy); end
        #2 nreset = 1'b0;
        #1;
        checks += 4;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid busy: got %b expected 0", busy); end
        if (apple_loc0 !== 8'h55) begin errors++; $display("FAIL reset_mid apple_loc0: got %h expected 55", apple_loc0); end
        if (apple_loc1 !== 8'h55) begin errors++; $display("FAIL reset_mid apple_loc1: got %h expected 55", apple_loc1); end
        if (rng_step !== 1'b0) begin errors++; $display("FAIL reset_mid rng_step: got %b expected 0", rng_step); end
        @(posedge system_clk); #1;
        nreset = 1'b1;
        exp_loc[0] = 8'h55; exp_loc[1] = 8'h55; m_rr = 1'b0;
        busy_cnt = 0;
        repeat (6) begin @(negedge system_clk); if (busy) busy_cnt++; end
        checks++;
        if (busy_cnt !== 0) begin errors++; $display("FAIL reset_mid pending cleared: got %0d busy cycles expected 0", busy_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rejects();
        test_fail();
        test_two_apple();
        test_random();
        test_abort();
        test_disable();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
